// File: rtl/serial_adder_pkg.sv
// Shared types and width helpers for the bit-serial adder.
package serial_adder_pkg;

  typedef enum logic {IDLE, RUN} sa_state_t;

  // Counter must address W-1; a width of zero is not representable, so floor at 1.
  function automatic int sa_cnt_w(input int w);
    return (w <= 1) ? 1 : $clog2(w);
  endfunction

endpackage

// File: rtl/serial_adder_fa.sv
// One-bit full-adder cell used by the serial adder.
module fa (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic cry
);

  assign s   = a ^ b ^ ci;
  assign cry = (a & b) | (a & ci) | (b & ci);

endmodule

// File: rtl/serial_adder.sv
// Bit-serial W-bit adder: LSB-first through one full-adder cell, one bit per cycle.
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] sum,
  output logic         cout
);

  localparam int CW = sa_cnt_w(W);
  localparam logic [CW-1:0] LAST = CW'(W - 1);

  sa_state_t     state;
  logic [W-1:0]  opa;
  logic [W-1:0]  opb;
  logic [W-1:0]  part;
  logic [W-1:0]  part_nxt;
  logic          carry;
  logic [CW-1:0] count;
  logic          s;
  logic          cry;

  fa u_fa (
    .a  (opa[0]),
    .b  (opb[0]),
    .ci (carry),
    .s  (s),
    .cry(cry)
  );

  // New sum bit enters at the MSB so that after W shifts bit 0 lands at the LSB.
  generate
    if (W == 1) begin : g_part1
      assign part_nxt = s;
    end else begin : g_partn
      assign part_nxt = {s, part[W-1:1]};
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
      sum   <= '0;
      cout  <= 1'b0;
      opa   <= '0;
      opb   <= '0;
      part  <= '0;
      carry <= 1'b0;
      count <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            opa   <= a;
            opb   <= b;
            carry <= cin;
            part  <= '0;
            count <= '0;
            busy  <= 1'b1;
            state <= RUN;
          end
        end
        RUN: begin
          part  <= part_nxt;
          opa   <= opa >> 1;
          opb   <= opb >> 1;
          carry <= cry;
          count <= count + CW'(1);
          if (count == LAST) begin
            sum   <= part_nxt;
            cout  <= cry;
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_adder.sv
// Scoreboard bench for serial_adder: reference model predicts results and timing.
module tb_serial_adder;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         cin = 1'b0;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         cout;

  serial_adder #(.W(W)) dut (
    .clk  (clk),
    .rst  (rst),
    .start(start),
    .a    (a),
    .b    (b),
    .cin  (cin),
    .busy (busy),
    .done (done),
    .sum  (sum),
    .cout (cout)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  // Reference model: a request is accepted when no addition is outstanding;
  // its result a+b+cin appears W edges later.
  logic [W:0] exp_q[$];
  int         rem = 0;
  logic       mdl_done = 1'b0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      rem      = 0;
      mdl_done = 1'b0;
      exp_q.delete();
    end else begin
      mdl_done = 1'b0;
      if (rem == 0) begin
        if (start) begin
          exp_q.push_back((W+1)'(a) + (W+1)'(b) + (W+1)'(cin));
          rem = W;
        end
      end else begin
        rem--;
        if (rem == 0) mdl_done = 1'b1;
      end
    end
  end

  // Monitor: checks outputs every cycle, pops the scoreboard on each done.
  logic [W:0] held = '0;

  always @(negedge clk) begin
    if (rst) held = '0;
    chk("busy", 32'(busy), 32'(rem != 0));
    chk("done", 32'(done), 32'(mdl_done));
    if (done) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_done at %0t: got done=1 expected no pending result", $time);
      end else begin
        held = exp_q.pop_front();
      end
    end
    chk("result", 32'({cout, sum}), 32'(held));
  end

  task automatic add_once(input logic [W-1:0] xa, input logic [W-1:0] xb, input logic xc);
    @(negedge clk);
    a = xa; b = xb; cin = xc; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
    repeat (W + 1) @(negedge clk);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    add_once(8'h35, 8'h1A, 1'b0);
    add_once(8'hFF, 8'h01, 1'b0);
    add_once(8'hFF, 8'hFF, 1'b1);

    // Start ignored while busy.
    @(negedge clk);
    a = 8'h10; b = 8'h20; cin = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    a = 8'hAA; b = 8'h55; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (W + 2) @(negedge clk);

    // Streaming with start held.
    a = 8'h01; b = 8'h01; cin = 1'b0; start = 1'b1;
    repeat (4 * (W + 1)) @(negedge clk);
    start = 1'b0;
    repeat (W + 2) @(negedge clk);

    // Asynchronous reset four cycles into RUN.
    a = 8'h77; b = 8'h99; cin = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_sum", 32'(sum), 32'd0);
    chk("rst_cout", 32'(cout), 32'd0);
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
    repeat (12) @(negedge clk);

    // cin path, then hold while inputs wander.
    add_once(8'h00, 8'h00, 1'b1);
    repeat (20) begin
      @(negedge clk);
      a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
    end

    // Random traffic with random gaps.
    repeat (30) begin
      add_once(W'($urandom), W'($urandom), 1'($urandom));
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end

    repeat (W + 2) @(negedge clk);
    chk("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
